// File: rtl/benes_pkg.sv
// Shared definitions for the Benes permutation pipeline: switch encoding, FSM states
// and the inter-stage wiring helper.
package benes_pkg;

   localparam logic PASS  = 1'b0;
   localparam logic CROSS = 1'b1;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // Destination port of source port p on the link after stage s. The first half of the
   // network unshuffles each block; the second half applies the mirrored inverse shuffle.
   function automatic int unsigned wire_dest(int unsigned n, int unsigned log_n,
                                             int unsigned s, int unsigned p);
      int unsigned b;
      int unsigned base;
      int unsigned i;
      int unsigned dest;
      if (s + 2 <= log_n) begin
         b    = n >> s;
         base = p - (p % b);
         i    = p % b;
         dest = (i % 2 == 0) ? base + i / 2 : base + b / 2 + i / 2;
      end else begin
         b    = n >> (2 * log_n - 3 - s);
         base = p - (p % b);
         i    = p % b;
         dest = (i < b / 2) ? base + 2 * i : base + 2 * (i - b / 2) + 1;
      end
      return dest;
   endfunction

endpackage

// File: rtl/benes_sw2.sv
// Combinational 2x2 crossbar element of the Benes network.
module benes_sw2
   import benes_pkg::*;
#(
   parameter int unsigned DW = 32
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          ctrl,
   output logic [DW-1:0] y,
   output logic [DW-1:0] z
);

   assign y = (ctrl == CROSS) ? b : a;
   assign z = (ctrl == CROSS) ? a : b;

endmodule

// File: rtl/benes_pipe.sv
// Configurable Benes permutation network with valid/ready handshake and safe config commit.
// Define BENES_STAGE_REG_EN to register every stage (latency STAGES); otherwise latency is 1.
module benes_pipe
   import benes_pkg::*;
#(
   parameter int unsigned N_PORTS = 32,
   parameter int unsigned DW      = 32
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [N_PORTS*DW-1:0]                 in_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [N_PORTS*DW-1:0]                 out_data,
   input  logic                                  cfg_we,
   input  logic [$clog2(2*$clog2(N_PORTS)-1)-1:0] cfg_stage,
   input  logic [N_PORTS/2-1:0]                  cfg_bits,
   input  logic                                  cfg_commit,
   output logic                                  cfg_busy
);

   localparam int unsigned LOG_N  = $clog2(N_PORTS);
   localparam int unsigned STAGES = 2 * LOG_N - 1;
   localparam int unsigned SW     = N_PORTS / 2;
   localparam int unsigned CSW    = $clog2(STAGES);
   localparam logic [CSW-1:0] STAGE_LIM = CSW'(STAGES);

   state_t                   state;
   logic                     busy;
   logic [STAGES-1:0][SW-1:0] shadow;
   logic [STAGES-1:0][SW-1:0] shadow_nxt;
   logic [STAGES-1:0][SW-1:0] active;
   logic                     advance;
   logic                     accept;
   logic                     all_idle;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && (state == RUN);
   assign accept   = in_valid && in_ready;
   assign cfg_busy = busy;

   // Shadow row write; out-of-range stage indices are dropped.
   always_comb begin
      shadow_nxt = shadow;
      if (cfg_we && (cfg_stage < STAGE_LIM)) begin
         shadow_nxt[cfg_stage] = cfg_bits;
      end
   end

   // Switch columns; q is what the next column sees (registered or pass-through).
   for (genvar s = 0; s < STAGES; s++) begin : g_st
      logic [N_PORTS-1:0][DW-1:0] din;
      logic [N_PORTS-1:0][DW-1:0] dout;
      logic [N_PORTS-1:0][DW-1:0] q;

      if (s == 0) begin : g_in
         assign din = in_data;
      end else begin : g_wire
         for (genvar p = 0; p < N_PORTS; p++) begin : g_p
            localparam int unsigned D = wire_dest(N_PORTS, LOG_N, s - 1, p);
            assign din[D] = g_st[s-1].q[p];
         end
      end

      for (genvar k = 0; k < SW; k++) begin : g_sw
         benes_sw2 #(.DW(DW)) u_sw (
            .a    (din[2*k]),
            .b    (din[2*k+1]),
            .ctrl (active[s][k]),
            .y    (dout[2*k]),
            .z    (dout[2*k+1])
         );
      end

`ifdef BENES_STAGE_REG_EN
      always_ff @(posedge clk) begin
         if (rst) begin
            q <= '0;
         end else if (advance) begin
            q <= dout;
         end
      end
`else
      assign q = dout;
`endif
   end

`ifdef BENES_STAGE_REG_EN
   logic [STAGES-1:0] vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
      end else if (advance) begin
         vld <= {vld[STAGES-2:0], accept};
      end
   end

   assign out_valid = vld[STAGES-1];
   assign out_data  = g_st[STAGES-1].q;
   assign all_idle  = (vld == '0);
`else
   logic                    vld;
   logic [N_PORTS*DW-1:0]   dreg;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld  <= 1'b0;
         dreg <= '0;
      end else if (advance) begin
         vld  <= accept;
         dreg <= g_st[STAGES-1].q;
      end
   end

   assign out_valid = vld;
   assign out_data  = dreg;
   assign all_idle  = !vld;
`endif

   // Commit sequencing: input is blocked until the pipe is empty, so no vector sees mixed config.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= RUN;
         busy   <= 1'b0;
         shadow <= '0;
         active <= '0;
      end else begin
         shadow <= shadow_nxt;
         case (state)
            RUN: begin
               if (cfg_commit) begin
                  state <= DRAIN;
                  busy  <= 1'b1;
               end
            end
            DRAIN: begin
               if (all_idle) begin
                  state <= COMMIT;
               end
            end
            COMMIT: begin
               active <= shadow_nxt;
               state  <= RUN;
               busy   <= 1'b0;
            end
            default: begin
               state <= RUN;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_benes_pipe.sv
// Scoreboard bench for benes_pipe (N_PORTS=4): random vectors against a shuffle-based model.
module tb_benes_pipe;

   localparam int N      = 4;
   localparam int DW     = 8;
   localparam int LOG_N  = 2;
   localparam int STAGES = 3;
   localparam int SW     = 2;
`ifdef BENES_STAGE_REG_EN
   localparam int LAT = STAGES;
`else
   localparam int LAT = 1;
`endif

   typedef logic [N*DW-1:0] vec_t;
   typedef logic [STAGES-1:0][SW-1:0] cfg_t;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   vec_t          in_data;
   logic          out_valid;
   logic          out_ready;
   vec_t          out_data;
   logic          cfg_we;
   logic [1:0]    cfg_stage;
   logic [SW-1:0] cfg_bits;
   logic          cfg_commit;
   logic          cfg_busy;

   benes_pipe #(.N_PORTS(N), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .cfg_we     (cfg_we),
      .cfg_stage  (cfg_stage),
      .cfg_bits   (cfg_bits),
      .cfg_commit (cfg_commit),
      .cfg_busy   (cfg_busy)
   );

   int   errors = 0;
   int   checks = 0;
   vec_t exp_q[$];
   cfg_t m_shadow;
   cfg_t m_active;
   int   rmode;   // 0 random ready, 1 always ready, 2 stalled

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: swap pairs per config bit, then unshuffle (first half) or interleave (second half).
   function automatic vec_t model(input vec_t v, input cfg_t c);
      logic [DW-1:0] cur[$];
      logic [DW-1:0] nxt[$];
      logic [DW-1:0] t;
      int b;
      vec_t r;
      for (int p = 0; p < N; p++) cur.push_back(v[p*DW +: DW]);
      for (int s = 0; s < STAGES; s++) begin
         for (int k = 0; k < SW; k++) begin
            if (c[s][k]) begin
               t = cur[2*k]; cur[2*k] = cur[2*k+1]; cur[2*k+1] = t;
            end
         end
         if (s == STAGES - 1) break;
         nxt.delete();
         if (s <= LOG_N - 2) begin
            b = N >> s;
            for (int base = 0; base < N; base += b) begin
               for (int i = 0; i < b; i += 2) nxt.push_back(cur[base+i]);
               for (int i = 1; i < b; i += 2) nxt.push_back(cur[base+i]);
            end
         end else begin
            b = N >> (2*LOG_N - 3 - s);
            for (int base = 0; base < N; base += b) begin
               for (int j = 0; j < b/2; j++) begin
                  nxt.push_back(cur[base+j]);
                  nxt.push_back(cur[base+b/2+j]);
               end
            end
         end
         cur = nxt;
      end
      for (int p = 0; p < N; p++) r[p*DW +: DW] = cur[p];
      return r;
   endfunction

   function automatic vec_t xor_perm(input vec_t v, input int m);
      vec_t r;
      for (int j = 0; j < N; j++) r[j*DW +: DW] = v[(j^m)*DW +: DW];
      return r;
   endfunction

   // Downstream ready generator.
   always @(posedge clk) begin
      #1;
      case (rmode)
         0:       out_ready = ($urandom_range(0, 3) != 0);
         1:       out_ready = 1'b1;
         default: out_ready = 1'b0;
      endcase
   end

   // Monitor: pops and compares on every transfer, checks hold and backpressure.
   logic prev_stall;
   vec_t prev_data;
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check("hold", out_data, prev_data);
         if (out_valid && !out_ready) check("in_ready_stall", in_ready, 1'b0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %0h expected none", out_data);
            end else begin
               check("data", out_data, exp_q.pop_front());
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   // Entered just after a posedge; returns just after the accepting posedge.
   task automatic send(input vec_t v, input vec_t e, input bit do_commit);
      int n;
      n = 0;
      in_data  = v;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 1000) begin
            check("send_timeout", 1'b1, 1'b0);
            in_valid = 1'b0;
            return;
         end
      end
      exp_q.push_back(e);
      if (do_commit) begin
         cfg_commit = 1'b1;
         m_active   = m_shadow;
      end
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      cfg_commit = 1'b0;
   endtask

   task automatic send_m(input vec_t v, input bit do_commit);
      send(v, model(v, m_active), do_commit);
   endtask

   task automatic cfg_write(input int st, input logic [SW-1:0] b, input bit cm);
      cfg_we     = 1'b1;
      cfg_stage  = 2'(st);
      cfg_bits   = b;
      cfg_commit = cm;
      @(posedge clk);
      #1;
      cfg_we     = 1'b0;
      cfg_commit = 1'b0;
      if (st < STAGES) m_shadow[st] = b;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (cfg_busy) begin
         n++;
         if (n > 500) begin
            check("busy_timeout", 1'b1, 1'b0);
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic finish_commit();
      @(negedge clk);
      check("busy_set", cfg_busy, 1'b1);
      wait_idle();
      m_active = m_shadow;
      @(posedge clk);
      #1;
   endtask

   task automatic drain_all();
      int n;
      n = 0;
      rmode = 1;
      @(negedge clk);
      while (exp_q.size() > 0) begin
         n++;
         if (n > 500) begin
            check("drain_timeout", 1'b1, 1'b0);
            return;
         end
         @(negedge clk);
      end
   endtask

   vec_t v;
   int   lat;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      cfg_we = 1'b0; cfg_stage = '0; cfg_bits = '0; cfg_commit = 1'b0;
      rmode = 1; m_shadow = '0; m_active = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_busy", cfg_busy, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;

      // Identity after reset, with latency measurement.
      for (int p = 0; p < N; p++) v[p*DW +: DW] = DW'(p + 1);
      send(v, v, 1'b0);
      lat = 0;
      forever begin
         @(negedge clk);
         lat++;
         if (out_valid || lat > 50) break;
      end
      check("latency", 64'(lat), 64'(LAT));
      @(posedge clk); #1;

      // Stage 0 all cross, write and commit in the same cycle.
      cfg_write(0, 2'b11, 1'b1);
      finish_commit();
      repeat (4) begin
         v = vec_t'($urandom());
         send(v, xor_perm(v, 1), 1'b0);
      end

      // All stages cross.
      cfg_write(1, 2'b11, 1'b0);
      cfg_write(2, 2'b11, 1'b1);
      finish_commit();
      repeat (4) begin
         v = vec_t'($urandom());
         send(v, xor_perm(v, 2), 1'b0);
      end

      // Out-of-range stage write must not change anything.
      cfg_write(3, 2'b01, 1'b1);
      finish_commit();
      repeat (3) begin
         v = vec_t'($urandom());
         send(v, xor_perm(v, 2), 1'b0);
      end

      // Random config, random stream with a stall window and a mid-stream commit.
      for (int s = 0; s < STAGES; s++) cfg_write(s, SW'($urandom()), s == STAGES - 1);
      finish_commit();
      rmode = 0;
      for (int i = 0; i < 100; i++) begin
         if (i == 20) begin
            drain_all();
            rmode = 2;
            @(posedge clk); #1;
            for (int j = 0; j < LAT; j++) send_m(vec_t'($urandom()), 1'b0);
            for (int j = 0; j < 5; j++) begin
               @(negedge clk);
               check("stall_out_valid", out_valid, 1'b1);
               check("stall_in_ready", in_ready, 1'b0);
            end
            rmode = 0;
            @(posedge clk); #1;
         end
         if (i == 50) begin
            for (int s = 0; s < STAGES; s++) cfg_write(s, SW'($urandom()), 1'b0);
         end
         send_m(vec_t'($urandom()), i == 50);
         if (i == 50) begin
            @(negedge clk);
            check("commit_busy", cfg_busy, 1'b1);
            check("commit_in_ready", in_ready, 1'b0);
            cfg_commit = 1'b1;
            @(posedge clk); #1;
            cfg_commit = 1'b0;
            wait_idle();
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               check("second_commit_ignored", cfg_busy, 1'b0);
            end
            @(posedge clk); #1;
         end
      end

      // Reset while draining abandons the commit.
      drain_all();
      rmode = 2;
      @(posedge clk); #1;
      cfg_write(0, 2'b01, 1'b0);
      for (int j = 0; j < LAT; j++) send_m(vec_t'($urandom()), 1'b0);
      cfg_write(1, 2'b10, 1'b1);
      @(negedge clk);
      check("drain_busy", cfg_busy, 1'b1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      m_shadow = '0;
      m_active = '0;
      rmode = 1;
      @(negedge clk);
      check("rst_drain_out_valid", out_valid, 1'b0);
      check("rst_drain_busy", cfg_busy, 1'b0);
      @(posedge clk); #1;
      repeat (3) begin
         v = vec_t'($urandom());
         send(v, v, 1'b0);
      end
      cfg_write(2, 2'b00, 1'b1);
      finish_commit();
      repeat (3) begin
         v = vec_t'($urandom());
         send(v, v, 1'b0);
      end

      drain_all();
      repeat (3) @(posedge clk);
      check("leftover", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
